rvsteel_io_arbiter: RTL

//  Two-manager arbiter for one RISC-V Steel IO subordinate port, e.g. rvsteel_gpio

---
 rtl/rvsteel_io_arbiter_if.sv | 35 +++
 rtl/rvsteel_io_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_io_arbiter_if.sv
// RISC-V Steel IO bus bundle: one address, read and write channel set.
// master: the side that issues requests (a manager, or the arbiter toward the subordinate).
// slave: the side that answers them (a subordinate, or the arbiter toward a manager).
interface rvsteel_io_arbiter_if;
  logic [31:0] rw_address;
  logic [31:0] read_data;
  logic        read_request;
  logic        read_response;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response;

  modport master (
    output rw_address,
    output read_request,
    output write_data,
    output write_strobe,
    output write_request,
    input  read_data,
    input  read_response,
    input  write_response
  );

  modport slave (
    input  rw_address,
    input  read_request,
    input  write_data,
    input  write_strobe,
    input  write_request,
    output read_data,
    output read_response,
    output write_response
  );
endinterface

// File: rtl/rvsteel_io_arbiter.sv
// Two-manager arbiter for a single RISC-V Steel IO subordinate port.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
// Arbitration is round-robin, or fixed priority for m0 when FIXED_PRIORITY is nonzero.
// Optional feature macro IO_ARBITER_TIMEOUT_EN adds a WAIT timeout that forces
// completion with read data 0 and a bus_error pulse.
module rvsteel_io_arbiter #(
  parameter int unsigned FIXED_PRIORITY = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  rvsteel_io_arbiter_if.slave  m0,
  rvsteel_io_arbiter_if.slave  m1,
  rvsteel_io_arbiter_if.master s,
  output logic                 bus_error
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;            // 0: m0, 1: m1
  logic        last_grant_q, last_grant_d;
  logic        is_write_q, is_write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strobe_q, strobe_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

`ifdef IO_ARBITER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timed_out_q, timed_out_d;
`endif

  logic pending0, pending1;
  logic grant;
  logic resp_match;

  assign pending0   = m0.read_request | m0.write_request;
  assign pending1   = m1.read_request | m1.write_request;
  assign resp_match = is_write_q ? s.write_response : s.read_response;

  // Pick the winner among pending managers; only meaningful when one is pending.
  always_comb begin
    if (pending0 && pending1) begin
      grant = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
    end else begin
      grant = pending1;
    end
  end

  // Next-state logic: arbitration, request latching and response capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strobe_d     = strobe_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
`ifdef IO_ARBITER_TIMEOUT_EN
    cnt_d        = cnt_q;
    timed_out_d  = timed_out_q;
`endif
    case (state_q)
      StIdle: begin
        if (pending0 || pending1) begin
          owner_d      = grant;
          last_grant_d = grant;
          // A manager raising both requests gets a write.
          if (grant) begin
            is_write_d = m1.write_request;
            addr_d     = m1.rw_address;
            wdata_d    = m1.write_data;
            strobe_d   = m1.write_strobe;
          end else begin
            is_write_d = m0.write_request;
            addr_d     = m0.rw_address;
            wdata_d    = m0.write_data;
            strobe_d   = m0.write_strobe;
          end
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef IO_ARBITER_TIMEOUT_EN
        cnt_d       = '0;
        timed_out_d = 1'b0;
`endif
      end
      StWait: begin
        if (resp_match) begin
          if (!is_write_q) begin
            if (owner_q) m1_rdata_d = s.read_data;
            else         m0_rdata_d = s.read_data;
          end
          state_d = StDone;
        end
`ifdef IO_ARBITER_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          if (!is_write_q) begin
            if (owner_q) m1_rdata_d = '0;
            else         m0_rdata_d = '0;
          end
          timed_out_d = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset drops any transaction in flight without a response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strobe_q     <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strobe_q     <= strobe_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

`ifdef IO_ARBITER_TIMEOUT_EN
  // WAIT cycle counter and timeout flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timed_out_q <= timed_out_d;
    end
  end
`endif

  // Subordinate and manager outputs decoded from state and latched transaction.
  always_comb begin
    s.rw_address      = addr_q;
    s.write_data      = wdata_q;
    s.write_strobe    = strobe_q;
    s.read_request    = (state_q == StIssue) && !is_write_q;
    s.write_request   = (state_q == StIssue) && is_write_q;
    m0.read_data      = m0_rdata_q;
    m1.read_data      = m1_rdata_q;
    m0.read_response  = (state_q == StDone) && !owner_q && !is_write_q;
    m0.write_response = (state_q == StDone) && !owner_q && is_write_q;
    m1.read_response  = (state_q == StDone) && owner_q && !is_write_q;
    m1.write_response = (state_q == StDone) && owner_q && is_write_q;
`ifdef IO_ARBITER_TIMEOUT_EN
    bus_error         = (state_q == StDone) && timed_out_q;
`else
    bus_error         = 1'b0;
`endif
  end

endmodule
